// File: rtl/mem_bus_pkg.sv
// Shared definitions for the cs/wen/addr/wdata/rdata memory bus endpoints.
// Holds default bus widths, the responder FSM encoding and a ceil-log2 helper.
package mem_bus_pkg;

    localparam int DEF_DW = 16;
    localparam int DEF_AW = 25;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-response delay line: LAT stages of valid/err/data with synchronous flush.
// in_data comes from a registered RAM read, so it is already aligned with stage 0.
module mem_rd_pipe #(
    parameter int DW  = 16,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          in_err,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic          out_err,
    output logic [DW-1:0] out_data
);

    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
        logic          valid_q;
        logic          err_q;
        logic [DW-1:0] data_q;

        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (flush) begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                end else begin
                    valid_q <= in_valid;
                    err_q   <= in_valid & in_err;
                end
            end
            assign data_q = in_data;
        end else begin : g_body
            always_ff @(posedge clk) begin
                if (flush) begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                end else begin
                    valid_q <= g_stage[gi-1].valid_q;
                    err_q   <= g_stage[gi-1].err_q;
                end
                data_q <= g_stage[gi-1].data_q;
            end
        end
    end

    assign out_valid = g_stage[LAT-1].valid_q;
    assign out_err   = g_stage[LAT-1].err_q;
    // Data lanes are never reset, so mask them whenever no good response is present.
    assign out_data  = (out_valid && !out_err) ? g_stage[LAT-1].data_q : '0;

endmodule

// File: rtl/mem_responder.sv
// Single-port memory endpoint: zero-fills storage after reset, then services
// reads through a fixed-latency pipeline and counts accepted accesses.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int AW         = DEF_AW,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             wen,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    wdata,
    output logic [DW-1:0]    rdata,
    output logic             rvalid,
    output logic             err,
    output logic             ready,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int IW    = clog2(DEPTH);

    state_t           state_reg, state_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic             ready_reg, ready_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] wr_cnt_reg, wr_cnt_next;
    logic [CNT_W-1:0] rd_cnt_reg, rd_cnt_next;

    logic [DW-1:0]    mem [DEPTH];
    logic [DW-1:0]    ram_q_reg;

    logic             in_range;
    logic [IW-1:0]    word;
    logic             mem_we;
    logic [IW-1:0]    mem_waddr;
    logic [DW-1:0]    mem_wdata;
    logic             rd_req;
    logic             rd_oor;
    logic             pipe_err;

    if (DEPTH_LOG2 < AW) begin : g_hi_bits
        assign in_range = ~|addr[AW-1:DEPTH_LOG2];
    end else begin : g_full_map
        assign in_range = 1'b1;
    end

    assign word = addr[IW-1:0];

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        ready_next  = ready_reg;
        err_next    = 1'b0;
        wr_cnt_next = wr_cnt_reg;
        rd_cnt_next = rd_cnt_reg;
        mem_we      = 1'b0;
        mem_waddr   = idx_reg;
        mem_wdata   = '0;
        rd_req      = 1'b0;
        rd_oor      = 1'b0;

        case (state_reg)
            ST_INIT: begin
                // Sweep zeros through the array; any bus access meanwhile is rejected.
                mem_we   = 1'b1;
                idx_next = idx_reg + 1'b1;
                err_next = cs;
                if (idx_reg == '1) begin
                    state_next = ST_RUN;
                    ready_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (cs) begin
                    if (wen) begin
                        if (in_range) begin
                            mem_we    = 1'b1;
                            mem_waddr = word;
                            mem_wdata = wdata;
                            if (wr_cnt_reg != '1) begin
                                wr_cnt_next = wr_cnt_reg + 1'b1;
                            end
                        end else begin
                            err_next = 1'b1;
                        end
                    end else begin
                        rd_req = 1'b1;
                        rd_oor = !in_range;
                        if (in_range && rd_cnt_reg != '1) begin
                            rd_cnt_next = rd_cnt_reg + 1'b1;
                        end
                    end
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_INIT;
            idx_reg    <= '0;
            ready_reg  <= 1'b0;
            err_reg    <= 1'b0;
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            ready_reg  <= ready_next;
            err_reg    <= err_next;
            wr_cnt_reg <= wr_cnt_next;
            rd_cnt_reg <= rd_cnt_next;
        end
    end

    // Storage keeps its contents across reset; only the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
        ram_q_reg <= mem[word];
    end

    mem_rd_pipe #(
        .DW  (DW),
        .LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .flush     (rst),
        .in_valid  (rd_req),
        .in_err    (rd_oor),
        .in_data   (ram_q_reg),
        .out_valid (rvalid),
        .out_err   (pipe_err),
        .out_data  (rdata)
    );

    assign err    = err_reg | pipe_err;
    assign ready  = ready_reg;
    assign wr_cnt = wr_cnt_reg;
    assign rd_cnt = rd_cnt_reg;

endmodule
